// File: rtl/io_bus_pkg.sv
// Shared IO-bus definitions: register offsets, status bit positions and the
// serialiser state type used by the UART blocks.
package io_bus_pkg;

   localparam logic [7:0] OFF_TX_DATA  = 8'h00;
   localparam logic [7:0] OFF_TX_STAT  = 8'h04;
   localparam logic [7:0] OFF_BAUD_DIV = 8'h08;

   localparam int STAT_NOT_FULL = 0;
   localparam int STAT_IDLE     = 1;
   localparam int STAT_OVF      = 2;
   localparam int STAT_CNT_LSB  = 4;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with separately held occupancy count; full/empty are
// decoded from the count, so a push is judged against the pre-pop state.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, TX FIFO, status/divisor
// registers and the bit serialiser.
module io_uart_tx
   import io_bus_pkg::*;
#(
   parameter logic [7:0] BASE        = 8'h20,
   parameter int         FIFO_DEPTH  = 16,
   parameter int         DEFAULT_DIV = 868
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  io_addr,
   input  logic [31:0] io_dout,
   input  logic        io_we,
   input  logic        io_rd,
   output logic [31:0] io_din,
   output logic        txd
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic            sel_data, sel_stat, sel_div;
   logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [7:0]      fifo_dout;
   logic [CW-1:0]   fifo_count;
   logic [15:0]     baud_div;
   logic            ovf;
   tx_state_e       state;
   logic [15:0]     bit_cnt;
   logic [15:0]     cur_div;
   logic [2:0]      bit_idx;
   logic [7:0]      shreg;
   logic            last_cyc;
   logic [31:0]     stat;
   logic            unused_hi;

   assign sel_data = (io_addr == 8'(BASE + OFF_TX_DATA));
   assign sel_stat = (io_addr == 8'(BASE + OFF_TX_STAT));
   assign sel_div  = (io_addr == 8'(BASE + OFF_BAUD_DIV));
   assign unused_hi = ^io_dout[31:16];

   assign fifo_push = io_we && sel_data;
   assign last_cyc  = (bit_cnt == cur_div - 16'd1);
   // Pop from IDLE, or straight out of the last stop-bit cycle for gapless frames.
   assign fifo_pop  = !fifo_empty &&
                      ((state == IDLE) || ((state == STOP) && last_cyc));

   sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (io_dout[7:0]),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_comb begin
      stat                      = '0;
      stat[STAT_NOT_FULL]       = !fifo_full;
      stat[STAT_IDLE]           = fifo_empty && (state == IDLE);
      stat[STAT_OVF]            = ovf;
      stat[STAT_CNT_LSB +: CW]  = fifo_count;
      io_din = '0;
      if (sel_stat)     io_din = stat;
      else if (sel_div) io_din = {16'h0000, baud_div};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         baud_div <= 16'(DEFAULT_DIV);
         ovf      <= 1'b0;
      end else begin
         if (io_we && sel_div)
            baud_div <= (io_dout[15:0] < 16'd2) ? 16'd2 : io_dout[15:0];
         // A fresh overflow beats a read-clear in the same cycle.
         if (fifo_push && fifo_full)  ovf <= 1'b1;
         else if (io_rd && sel_stat)  ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         txd     <= 1'b1;
         bit_cnt <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         cur_div <= 16'(DEFAULT_DIV);
      end else if (fifo_pop) begin
         shreg   <= fifo_dout;
         cur_div <= baud_div;
         bit_cnt <= '0;
         txd     <= 1'b0;
         state   <= START;
      end else begin
         case (state)
            IDLE: txd <= 1'b1;
            START: begin
               if (last_cyc) begin
                  bit_cnt <= '0;
                  bit_idx <= '0;
                  txd     <= shreg[0];
                  shreg   <= shreg >> 1;
                  state   <= DATA;
               end else bit_cnt <= bit_cnt + 16'd1;
            end
            DATA: begin
               if (last_cyc) begin
                  bit_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     txd   <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     txd     <= shreg[0];
                     shreg   <= shreg >> 1;
                  end
               end else bit_cnt <= bit_cnt + 16'd1;
            end
            STOP: begin
               if (last_cyc) begin
                  bit_cnt <= '0;
                  state   <= IDLE;
               end else bit_cnt <= bit_cnt + 16'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx: register reads checked inline, serial frames
// checked by a txd monitor against a queue of expected bytes and divisors.
module tb_io_uart_tx;

   localparam logic [7:0] A_DATA = 8'h20;
   localparam logic [7:0] A_STAT = 8'h24;
   localparam logic [7:0] A_DIV  = 8'h28;

   typedef struct {
      logic [7:0] b;
      int         div;
      bit         contig;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  io_addr = '0;
   logic [31:0] io_dout = '0;
   logic        io_we = 1'b0;
   logic        io_rd = 1'b0;
   logic [31:0] io_din;
   logic        txd;

   int   n_vec = 0;
   int   n_bad = 0;
   exp_t sbq[$];

   always #5 clk = ~clk;

   io_uart_tx #(.BASE(8'h20), .FIFO_DEPTH(16), .DEFAULT_DIV(868)) dut (
      .clk     (clk),
      .rst     (rst),
      .io_addr (io_addr),
      .io_dout (io_dout),
      .io_we   (io_we),
      .io_rd   (io_rd),
      .io_din  (io_din),
      .txd     (txd)
   );

   // ---------------- txd monitor / scoreboard ----------------
   int         cyc = 0;
   int         m_end = -1;
   int         m_k, m_pos;
   bit         m_act = 0, m_bad, m_skip;
   logic       m_expb;
   logic [7:0] m_rx;
   exp_t       m_e;

   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         m_act = 0;
         m_end = -1;
         sbq.delete();
      end else begin
         if (!m_act && txd == 1'b0) begin
            m_act = 1; m_k = 0; m_bad = 0; m_skip = 0; m_rx = '0;
            if (sbq.size() == 0) begin
               n_vec++; n_bad++; m_skip = 1;
               m_e = '{8'h00, 4, 1'b0};
               $display("FAIL spurious_start: txd low at cycle %0d, want idle high", cyc);
            end else begin
               m_e = sbq.pop_front();
               if (m_e.contig) begin
                  n_vec++;
                  if (cyc != m_end) begin
                     n_bad++;
                     $display("FAIL frame_gap: start at cycle %0d, want %0d", cyc, m_end);
                  end
               end
            end
         end
         if (m_act) begin
            m_pos  = m_k / m_e.div;
            m_expb = (m_pos == 0) ? 1'b0 : (m_pos == 9) ? 1'b1 : m_e.b[m_pos-1];
            if (txd !== m_expb) m_bad = 1;
            if (m_pos >= 1 && m_pos <= 8 && (m_k % m_e.div) == m_e.div / 2)
               m_rx[m_pos-1] = txd;
            m_k++;
            if (m_k == 10 * m_e.div) begin
               m_act = 0;
               m_end = cyc + 1;
               if (!m_skip) begin
                  n_vec++;
                  if (m_bad) begin
                     n_bad++;
                     $display("FAIL frame: got byte %02h (bit shape bad), want %02h at div %0d",
                              m_rx, m_e.b, m_e.div);
                  end
               end
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic bus(input logic we, input logic rd, input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      io_we = we; io_rd = rd; io_addr = a; io_dout = d;
   endtask

   task automatic nop();
      bus(1'b0, 1'b0, 8'h00, 32'h0);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, want %08h", name, act, exp);
      end
   endtask

   task automatic rd_chk(input logic [7:0] a, input logic rd, input logic [31:0] exp, input string name);
      bus(1'b0, rd, a, 32'h0);
      #1;
      check(name, io_din, exp);
   endtask

   task automatic push_byte(input logic [7:0] b, input int div, input bit contig);
      sbq.push_back('{b, div, contig});
      bus(1'b1, 1'b0, A_DATA, {24'h0, b});
   endtask

   task automatic wait_idle(input int budget, input string name);
      bit done = 0;
      for (int i = 0; i < budget && !done; i++) begin
         bus(1'b0, 1'b0, A_STAT, 32'h0);
         #1;
         if (io_din[1]) done = 1;
      end
      n_vec++;
      if (!done) begin
         n_bad++;
         $display("FAIL %s: not idle after %0d cycles, want idle", name, budget);
      end
   endtask

   logic [7:0] burst [17] = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80, 8'h7E, 8'h81,
                              8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h0F};
   logic [7:0] rbytes [6] = '{8'hC5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h66};

   initial begin
      int low;
      // Reset state.
      repeat (3) nop();
      check("txd_in_reset", {31'h0, txd}, 32'h1);
      rst = 1'b0;
      rd_chk(A_STAT, 1'b0, 32'h0000_0003, "rst_stat");
      rd_chk(A_DIV,  1'b0, 32'd868,       "rst_div");
      rd_chk(A_DATA, 1'b0, 32'h0,         "rst_data");
      rd_chk(8'h10,  1'b0, 32'h0,         "unmapped_10");
      rd_chk(8'h2C,  1'b0, 32'h0,         "unmapped_2c");
      check("txd_idle", {31'h0, txd}, 32'h1);
      bus(1'b1, 1'b0, A_STAT, 32'hFFFF_FFFF);
      rd_chk(A_STAT, 1'b0, 32'h0000_0003, "stat_write_ignored");

      // Single frame 0xA5 at div 4: latency and idle timing.
      bus(1'b1, 1'b0, A_DIV, 32'd4);
      push_byte(8'hA5, 4, 1'b0);                       // push edge t
      rd_chk(A_STAT, 1'b0, 32'h0000_0011, "push_stat"); // count 1, busy
      check("txd_before_pop", {31'h0, txd}, 32'h1);
      nop();
      check("txd_start_low", {31'h0, txd}, 32'h0);      // popped at t+1
      repeat (38) nop();
      rd_chk(A_STAT, 1'b0, 32'h0000_0001, "stop_not_idle");
      rd_chk(A_STAT, 1'b0, 32'h0000_0003, "idle_after_40");
      rd_chk(A_DATA, 1'b0, 32'h0, "data_reads_zero");

      // 17-byte burst: 17 pushed, first already popped, no overflow.
      for (int i = 0; i < 17; i++) push_byte(burst[i], 4, i != 0);
      rd_chk(A_STAT, 1'b0, 32'h0000_0100, "burst_stat");
      wait_idle(1000, "burst_drain");
      check("burst_sb_empty", sbq.size(), 32'd0);

      // Overflow at div 100: 18th byte dropped.
      bus(1'b1, 1'b0, A_DIV, 32'd100);
      for (int i = 0; i < 18; i++) begin
         if (i < 17) push_byte(burst[16-i], 100, i != 0);
         else        bus(1'b1, 1'b0, A_DATA, 32'h0000_00EE);
      end
      rd_chk(A_STAT, 1'b1, 32'h0000_0104, "ovf_set");
      rd_chk(A_STAT, 1'b0, 32'h0000_0100, "ovf_cleared");
      wait_idle(18000, "ovf_drain");
      check("ovf_sb_empty", sbq.size(), 32'd0);

      // Divisor clamp and mid-frame change.
      bus(1'b1, 1'b0, A_DIV, 32'd0);
      rd_chk(A_DIV, 1'b0, 32'd2, "div_clamp0");
      bus(1'b1, 1'b0, A_DIV, 32'd1);
      rd_chk(A_DIV, 1'b0, 32'd2, "div_clamp1");
      push_byte(8'h3C, 2, 1'b0);
      push_byte(8'hC3, 6, 1'b1);
      repeat (4) nop();
      bus(1'b1, 1'b0, A_DIV, 32'hABCD_0006);
      rd_chk(A_DIV, 1'b0, 32'd6, "div_mid_frame");
      wait_idle(300, "div_drain");
      check("div_sb_empty", sbq.size(), 32'd0);

      // Reset during data bit 3 with 5 bytes queued.
      bus(1'b1, 1'b0, A_DIV, 32'd4);
      for (int i = 0; i < 6; i++) push_byte(rbytes[i], 4, i != 0);  // edges t..t+5
      repeat (12) nop();
      nop();
      rst = 1'b1;                                       // reset edge t+18
      rd_chk(A_STAT, 1'b0, 32'h0000_0003, "rst_mid_stat");
      check("rst_mid_txd", {31'h0, txd}, 32'h1);
      nop();
      rst = 1'b0;
      rd_chk(A_DIV, 1'b0, 32'd868, "rst_mid_div");
      check("sb_flushed", sbq.size(), 32'd0);
      low = 0;
      repeat (300) begin
         nop();
         if (txd !== 1'b1) low++;
      end
      check("no_frames_after_rst", low, 32'd0);
      rd_chk(A_STAT, 1'b0, 32'h0000_0003, "final_stat");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog");
   end

endmodule
